// File: rtl/osecpu_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package osecpu_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: one-hot grant, bit 0 = fetch, bit 1 = load/store.
// Latency: purely combinational; no backpressure, the caller gates when grants are allowed.
module rr_arbiter2
    import osecpu_mem_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == REQ_LS) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between fetch and load/store, round-robin, one transaction in flight.
// Latency: mem_en one cycle after gnt, read data MEM_LAT+2 cycles after gnt; requesters hold req until gnt.
module mem_arbiter
    import osecpu_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    req_id_e           last_q, last_d;
    req_id_e           owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic [1:0]        arb_gnt;
    logic [1:0]        pick;

    rr_arbiter2 u_rr (
        .req  ({ls_req, if_req}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // Grants exist only in IDLE and are suppressed while reset is held.
    assign pick = (state_q == IDLE && reset) ? arb_gnt : 2'b00;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick[1]) begin
                    state_d     = ACCESS;
                    mem_en_d    = 1'b1;
                    owner_d     = REQ_LS;
                    last_d      = REQ_LS;
                    mem_we_d    = ls_we;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                end else if (pick[0]) begin
                    state_d    = ACCESS;
                    mem_en_d   = 1'b1;
                    owner_d    = REQ_IF;
                    last_d     = REQ_IF;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            ACCESS: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (owner_q == REQ_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= REQ_LS;
            owner_q     <= REQ_IF;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign if_gnt    = pick[0];
    assign ls_gnt    = pick[1];
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (MEM_LAT 1 and 3), each with a latency-accurate memory stand-in.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            gap;
        int            hold;
    } stim_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int lanes_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h0F0F_3C3C;
    endfunction

    function automatic stim_t mk(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                                 input int gap, input int hold);
        stim_t s;
        s.addr = a; s.we = we; s.wdata = wd; s.gap = gap; s.hold = hold;
        return s;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic          rst_n = 1'b1;
        logic          if_req, if_gnt, if_rvalid;
        logic [AW-1:0] if_addr;
        logic [DW-1:0] if_rdata;
        logic          ls_req, ls_we, ls_gnt, ls_rvalid;
        logic [AW-1:0] ls_addr;
        logic [DW-1:0] ls_wdata, ls_rdata;
        logic          mem_en, mem_we, busy;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata, mem_rdata;

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk(clk), .reset(rst_n),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
            .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy)
        );

        // Memory stand-in: read word appears exactly LAT cycles after the mem_en cycle, garbage otherwise.
        logic [DW-1:0] macro_mem [logic [AW-1:0]];
        logic [DW-1:0] ref_mem   [logic [AW-1:0]];
        logic [DW-1:0] pipe [LAT];
        assign mem_rdata = pipe[LAT-1];

        function automatic logic [DW-1:0] macro_rd(input logic [AW-1:0] a);
            return macro_mem.exists(a) ? macro_mem[a] : init_word(a);
        endfunction

        function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
            return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
        endfunction

        always @(posedge clk) begin
            if (mem_en && mem_we) macro_mem[mem_addr] = mem_wdata;
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= (mem_en && !mem_we) ? macro_rd(mem_addr) : {16'hBAD0, 16'($urandom)};
        end

        stim_t if_stim[$], ls_stim[$];
        exp_t  if_exp[$],  ls_exp[$];
        logic  if_act = 1'b0, ls_act = 1'b0;
        int    if_hold = 0, ls_hold = 0;

        // Driver: issues queued requests; on each accepted read pushes the word the memory must return.
        initial begin : drv
            stim_t s;
            exp_t  e;
            logic  dropped;
            if_req = 1'b0; if_addr = '0;
            ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
            forever begin
                @(negedge clk);
                if (rst_n && if_req && if_gnt) begin
                    e.data = ref_rd(if_addr);
                    e.due  = cyc + LAT + 2;
                    if_exp.push_back(e);
                    if_act = 1'b0;
                end
                if (rst_n && ls_req && ls_gnt) begin
                    if (ls_we) begin
                        ref_mem[ls_addr] = ls_wdata;
                    end else begin
                        e.data = ref_rd(ls_addr);
                        e.due  = cyc + LAT + 2;
                        ls_exp.push_back(e);
                    end
                    ls_act = 1'b0;
                end
                @(posedge clk);
                #1;
                dropped = 1'b0;
                if (if_act && if_hold > 0) begin
                    if_hold--;
                    if (if_hold == 0) begin if_act = 1'b0; dropped = 1'b1; end
                end
                if (!if_act && !dropped && if_stim.size() > 0) begin
                    s = if_stim[0];
                    if (s.gap > 0) begin
                        s.gap--;
                        if_stim[0] = s;
                    end else begin
                        if_stim.delete(0);
                        if_act = 1'b1; if_hold = s.hold; if_addr = s.addr;
                    end
                end
                if_req = if_act;
                dropped = 1'b0;
                if (ls_act && ls_hold > 0) begin
                    ls_hold--;
                    if (ls_hold == 0) begin ls_act = 1'b0; dropped = 1'b1; end
                end
                if (!ls_act && !dropped && ls_stim.size() > 0) begin
                    s = ls_stim[0];
                    if (s.gap > 0) begin
                        s.gap--;
                        ls_stim[0] = s;
                    end else begin
                        ls_stim.delete(0);
                        ls_act = 1'b1; ls_hold = s.hold;
                        ls_addr = s.addr; ls_we = s.we; ls_wdata = s.wdata;
                    end
                end
                ls_req = ls_act;
            end
        end

        // Monitor: cycle-level reference of grant rules, memory port and read returns.
        initial begin : mon
            int            free_c = 0;
            int            en_c   = -1;
            logic          last_ls = 1'b1;
            logic [AW-1:0] e_addr  = '0;
            logic          e_we    = 1'b0;
            logic [DW-1:0] e_wdata = '0;
            logic [DW-1:0] if_last = '0;
            logic [DW-1:0] ls_last = '0;
            logic          e_if, e_ls, e_ifv, e_lsv;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk("reset_outputs", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, busy,
                                          |if_rdata, |ls_rdata, |mem_addr, |mem_wdata}, 64'd0);
                    free_c = cyc + 1; en_c = -1; last_ls = 1'b1;
                    e_addr = '0; e_we = 1'b0; e_wdata = '0; if_last = '0; ls_last = '0;
                    if_exp.delete(); ls_exp.delete();
                end else begin
                    chk("mem_en", mem_en, cyc == en_c);
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_we", mem_we, e_we);
                    chk("mem_wdata", mem_wdata, e_wdata);
                    chk("busy", busy, (cyc >= en_c) && (cyc < free_c));
                    e_if = 1'b0; e_ls = 1'b0;
                    if (cyc >= free_c) begin
                        if (if_req && ls_req) begin
                            e_if = last_ls; e_ls = !last_ls;
                        end else begin
                            e_if = if_req; e_ls = ls_req;
                        end
                    end
                    chk("if_gnt", if_gnt, e_if);
                    chk("ls_gnt", ls_gnt, e_ls);
                    if (e_if || e_ls) begin
                        last_ls = e_ls;
                        en_c    = cyc + 1;
                        e_addr  = e_ls ? ls_addr : if_addr;
                        e_we    = e_ls && ls_we;
                        if (e_ls) e_wdata = ls_wdata;
                        free_c  = (e_ls && ls_we) ? cyc + 2 : cyc + LAT + 2;
                    end
                    e_ifv = (if_exp.size() > 0) && (if_exp[0].due == cyc);
                    chk("if_rvalid", if_rvalid, e_ifv);
                    if (e_ifv) begin if_last = if_exp[0].data; if_exp.delete(0); end
                    chk("if_rdata", if_rdata, if_last);
                    e_lsv = (ls_exp.size() > 0) && (ls_exp[0].due == cyc);
                    chk("ls_rvalid", ls_rvalid, e_lsv);
                    if (e_lsv) begin ls_last = ls_exp[0].data; ls_exp.delete(0); end
                    chk("ls_rdata", ls_rdata, ls_last);
                end
            end
        end

        task automatic wait_idle(input string nm);
            int n = 0;
            while ((if_stim.size() > 0 || ls_stim.size() > 0 || if_act || ls_act ||
                    if_exp.size() > 0 || ls_exp.size() > 0 || busy) && n < 2000) begin
                @(posedge clk);
                n++;
            end
            if (n >= 2000) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_idle: lane %0d still busy after %0d cycles, required idle", nm, g, n);
            end
            repeat (2) @(posedge clk);
        endtask

        initial begin : script
            stim_t s;
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;

            for (int i = 0; i < 4; i++) begin
                if_stim.push_back(mk(16'h0100 + 16'(i), 1'b0, '0, 0, 0));
                ls_stim.push_back(mk(16'h0200 + 16'(i), 1'b0, '0, 0, 0));
            end
            wait_idle("dual_alternate");

            macro_mem[16'h0010] = 32'hF000_0000;
            ref_mem[16'h0010]   = 32'hF000_0000;
            if_stim.push_back(mk(16'h0010, 1'b0, '0, 0, 0));
            wait_idle("if_read_0010");

            ls_stim.push_back(mk(16'h1234, 1'b1, 32'hDEAD_BEEF, 0, 0));
            if_stim.push_back(mk(16'h1234, 1'b0, '0, 1, 0));
            wait_idle("ls_write_then_if");

            ls_stim.push_back(mk(16'h1234, 1'b0, '0, 0, 0));
            ls_stim.push_back(mk(16'h0777, 1'b0, '0, 2, 0));
            wait_idle("ls_read");

            if_stim.push_back(mk(16'h0321, 1'b0, '0, 0, 0));
            for (int k = 0; k < 50 && !mem_en; k++) @(negedge clk);
            @(posedge clk);
            #2;
            chk("busy_before_reset", busy, 1'b1);
            rst_n = 1'b0;
            #1;
            chk("async_reset_outputs", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, busy,
                                        |if_rdata, |ls_rdata, |mem_addr, |mem_wdata}, 64'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            if_stim.push_back(mk(16'h0044, 1'b0, '0, 0, 0));
            ls_stim.push_back(mk(16'h0055, 1'b0, '0, 0, 0));
            wait_idle("after_reset_tie");

            for (int i = 0; i < 5; i++)
                if_stim.push_back(mk(16'($urandom), 1'b0, '0, 0, 0));
            wait_idle("if_back_to_back");

            for (int i = 0; i < 60; i++) begin
                s = mk(16'($urandom_range(0, 15)), 1'b0, $urandom, $urandom_range(0, 3),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
                if ($urandom_range(0, 1) == 0) begin
                    if_stim.push_back(s);
                end else begin
                    s.we = ($urandom_range(0, 2) == 0);
                    ls_stim.push_back(s);
                end
            end
            wait_idle("random");

            lanes_done++;
        end
    end

    initial begin : summary
        int n = 0;
        while (lanes_done < 2 && n < 30000) begin
            @(posedge clk);
            n++;
        end
        if (lanes_done < 2) begin
            n_cmp++; n_bad++;
            $display("FAIL sim_timeout: lanes finished %0d, required 2", lanes_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
